freq_sweep_ctrl: RTL and testbench

Frequency-control sequencer that owns the 8-bit `freq_ctrl` word feeding the wave generator and the theoretical-frequency calculator. It replaces the free-running up/down/clear register in the top level. In IDLE it applies manual step requests from the debounced push-buttons. On request it runs an automatic sweep, stepping `freq_ctrl` from a low to a high bound with a programmable dwell per step, in one-shot or ping-pong fashion. It runs in the `clk_100kHz` domain, next to the debouncers and `wave_generator`.

---
 rtl/freq_sweep_pkg.sv | 25 ++
 rtl/freq_sweep_ctrl_dwell_timer.sv | 43 ++++
 rtl/freq_sweep_ctrl.sv | 170 +++++++++++++++++
 tb/tb_freq_sweep_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/freq_sweep_pkg.sv
// Shared types and constants for the freq_ctrl sequencer: FSM states, sweep
// direction, default control-word bounds and the widened next-value width.
package freq_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DWELL = 2'd2
  } state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [7:0] CTRL_MIN_DEF = 8'd1;
  localparam logic [7:0] CTRL_MAX_DEF = 8'd128;
  localparam int         NXT_W        = 9;

  // Limit a widened sum to the upper bound; carries past 255 land above hi too.
  function automatic logic [7:0] clamp_hi(input logic [NXT_W-1:0] v, input logic [7:0] hi);
    return (v > {1'b0, hi}) ? hi : v[7:0];
  endfunction

endpackage

// File: rtl/freq_sweep_ctrl_dwell_timer.sv
// Dwell counter: counts enabled cycles and flags the last cycle of each dwell.
module dwell_timer
  import freq_sweep_pkg::*;
#(
  parameter int DWELL_TICKS = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int            CW   = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL_TICKS - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count and the expire flag; the counter wraps to zero on expire.
  always_comb begin
    cnt_d  = cnt_q;
    expire = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        expire = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/freq_sweep_ctrl.sv
// Owns the freq_ctrl word: manual up/down/clear in IDLE, and an automatic
// one-shot or ping-pong sweep between latched bounds with a fixed dwell.
module freq_sweep_ctrl
  import freq_sweep_pkg::*;
#(
  parameter int         DWELL_TICKS = 100000,
  parameter logic [7:0] CTRL_MIN    = CTRL_MIN_DEF,
  parameter logic [7:0] CTRL_MAX    = CTRL_MAX_DEF
) (
  input  logic       clk_100kHz,
  input  logic       rst_,
  input  logic       inc_pulse,
  input  logic       dec_pulse,
  input  logic       clr_pulse,
  input  logic       start_pulse,
  input  logic       stop_pulse,
  input  logic [7:0] sweep_lo,
  input  logic [7:0] sweep_hi,
  input  logic [7:0] sweep_step,
  input  logic       pingpong,
  output logic [7:0] freq_ctrl,
  output logic       ctrl_valid,
  output logic       busy,
  output logic       sweep_done,
  output logic       cfg_err
);

  state_e     state_q, state_d;
  dir_e       dir_q, dir_d;
  logic [7:0] freq_q, freq_d, lo_q, lo_d, hi_q, hi_d, step_q, step_d;
  logic       pp_q, pp_d, chg_q, chg_d;
  logic       ctrl_valid_q, ctrl_valid_d, busy_q, busy_d;
  logic       sweep_done_q, sweep_done_d, cfg_err_q, cfg_err_d;

  logic             expire_s;
  logic [7:0]       eff_lo_s, eff_hi_s, eff_step_s;
  logic [NXT_W-1:0] up_sum_s, dn_dif_s;
  logic             up_ok_s, dn_ok_s;

  assign eff_lo_s   = (sweep_lo < CTRL_MIN) ? CTRL_MIN : sweep_lo;
  assign eff_hi_s   = (sweep_hi > CTRL_MAX) ? CTRL_MAX : sweep_hi;
  assign eff_step_s = (sweep_step == 8'd0) ? 8'd1 : sweep_step;

  // Bit 8 of the difference marks an underflow below zero.
  assign up_sum_s = {1'b0, freq_q} + {1'b0, step_q};
  assign dn_dif_s = {1'b0, freq_q} - {1'b0, step_q};
  assign up_ok_s  = (up_sum_s <= {1'b0, hi_q});
  assign dn_ok_s  = !dn_dif_s[8] && (dn_dif_s[7:0] >= lo_q);

  dwell_timer #(.DWELL_TICKS(DWELL_TICKS)) u_dwell_timer (
    .clk    (clk_100kHz),
    .rst_n  (rst_),
    .clear  (state_q != ST_DWELL),
    .enable (state_q == ST_DWELL),
    .expire (expire_s)
  );

  // Next-state, next freq_ctrl and output pulse computation.
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    freq_d       = freq_q;
    lo_d         = lo_q;
    hi_d         = hi_q;
    step_d       = step_q;
    pp_d         = pp_q;
    sweep_done_d = 1'b0;
    cfg_err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_pulse) begin
          if (stop_pulse) begin
            state_d = ST_IDLE;
          end else if (eff_lo_s > eff_hi_s) begin
            cfg_err_d = 1'b1;
          end else begin
            lo_d    = eff_lo_s;
            hi_d    = eff_hi_s;
            step_d  = eff_step_s;
            pp_d    = pingpong;
            state_d = ST_LOAD;
          end
        end else if (clr_pulse) begin
          freq_d = CTRL_MIN;
        end else if (inc_pulse) begin
          freq_d = (freq_q == CTRL_MAX) ? CTRL_MIN : freq_q + 8'd1;
        end else if (dec_pulse) begin
          freq_d = (freq_q == CTRL_MIN) ? CTRL_MAX : freq_q - 8'd1;
        end else begin
          freq_d = freq_q;
        end
      end
      ST_LOAD: begin
        if (stop_pulse) begin
          state_d = ST_IDLE;
        end else begin
          freq_d  = lo_q;
          dir_d   = DIR_UP;
          state_d = ST_DWELL;
        end
      end
      ST_DWELL: begin
        if (stop_pulse) begin
          state_d = ST_IDLE;
        end else if (!expire_s) begin
          state_d = ST_DWELL;
        end else if (dir_q == DIR_UP) begin
          if (up_ok_s) begin
            freq_d = up_sum_s[7:0];
          end else if (pp_q) begin
            dir_d  = DIR_DOWN;
            freq_d = dn_ok_s ? dn_dif_s[7:0] : lo_q;
          end else begin
            state_d      = ST_IDLE;
            sweep_done_d = 1'b1;
          end
        end else begin
          if (dn_ok_s) begin
            freq_d = dn_dif_s[7:0];
          end else begin
            dir_d  = DIR_UP;
            freq_d = clamp_hi(up_sum_s, hi_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    chg_d        = (freq_d != freq_q);
    ctrl_valid_d = chg_q;
    busy_d       = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_100kHz or negedge rst_) begin
    if (!rst_) begin
      state_q      <= ST_IDLE;
      dir_q        <= DIR_UP;
      freq_q       <= CTRL_MIN;
      lo_q         <= CTRL_MIN;
      hi_q         <= CTRL_MAX;
      step_q       <= 8'd1;
      pp_q         <= 1'b0;
      chg_q        <= 1'b0;
      ctrl_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      sweep_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      freq_q       <= freq_d;
      lo_q         <= lo_d;
      hi_q         <= hi_d;
      step_q       <= step_d;
      pp_q         <= pp_d;
      chg_q        <= chg_d;
      ctrl_valid_q <= ctrl_valid_d;
      busy_q       <= busy_d;
      sweep_done_q <= sweep_done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign freq_ctrl  = freq_q;
  assign ctrl_valid = ctrl_valid_q;
  assign busy       = busy_q;
  assign sweep_done = sweep_done_q;
  assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Directed bench for freq_sweep_ctrl with a 4-cycle dwell.
module tb_freq_sweep_ctrl;

  logic       clk_100kHz = 1'b0;
  logic       rst_ = 1'b0;
  logic       inc_pulse = 1'b0, dec_pulse = 1'b0, clr_pulse = 1'b0;
  logic       start_pulse = 1'b0, stop_pulse = 1'b0;
  logic [7:0] sweep_lo = 8'd0, sweep_hi = 8'd0, sweep_step = 8'd0;
  logic       pingpong = 1'b0;
  logic [7:0] freq_ctrl;
  logic       ctrl_valid, busy, sweep_done, cfg_err;

  int checks = 0;
  int errors = 0;

  freq_sweep_ctrl #(.DWELL_TICKS(4)) dut (
    .clk_100kHz  (clk_100kHz),
    .rst_        (rst_),
    .inc_pulse   (inc_pulse),
    .dec_pulse   (dec_pulse),
    .clr_pulse   (clr_pulse),
    .start_pulse (start_pulse),
    .stop_pulse  (stop_pulse),
    .sweep_lo    (sweep_lo),
    .sweep_hi    (sweep_hi),
    .sweep_step  (sweep_step),
    .pingpong    (pingpong),
    .freq_ctrl   (freq_ctrl),
    .ctrl_valid  (ctrl_valid),
    .busy        (busy),
    .sweep_done  (sweep_done),
    .cfg_err     (cfg_err)
  );

  always #5 clk_100kHz = ~clk_100kHz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_freq"}, freq_ctrl, 8'd1);
    chk({tag, "_valid"}, ctrl_valid, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, sweep_done, 1'b0);
    chk({tag, "_cfgerr"}, cfg_err, 1'b0);
  endtask

  // which: 0 = inc, 1 = dec, 2 = clr
  task automatic man_step(input int which, input logic [7:0] exp);
    inc_pulse = (which == 0);
    dec_pulse = (which == 1);
    clr_pulse = (which == 2);
    @(negedge clk_100kHz);
    inc_pulse = 1'b0; dec_pulse = 1'b0; clr_pulse = 1'b0;
    chk("man_freq", freq_ctrl, exp);
    chk("man_valid_early", ctrl_valid, 1'b0);
    @(negedge clk_100kHz);
    chk("man_valid", ctrl_valid, 1'b1);
    @(negedge clk_100kHz);
    chk("man_valid_once", ctrl_valid, 1'b0);
  endtask

  task automatic start_sweep(input logic [7:0] lo, input logic [7:0] hi,
                             input logic [7:0] st, input logic pp);
    sweep_lo = lo; sweep_hi = hi; sweep_step = st; pingpong = pp;
    start_pulse = 1'b1;
    @(negedge clk_100kHz);
    start_pulse = 1'b0;
  endtask

  task automatic hold(input logic [7:0] v);
    for (int i = 0; i < 4; i++) begin
      chk("hold_freq", freq_ctrl, v);
      chk("hold_busy", busy, 1'b1);
      @(negedge clk_100kHz);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk_100kHz);
    chk_reset_outputs("reset");
    rst_ = 1'b1;
    @(negedge clk_100kHz);

    man_step(0, 8'd2);
    man_step(0, 8'd3);
    man_step(0, 8'd4);
    man_step(2, 8'd1);
    man_step(1, 8'd128);
    man_step(0, 8'd1);

    // One-shot 10..20 step 5
    start_sweep(8'd10, 8'd20, 8'd5, 1'b0);
    chk("os_load_busy", busy, 1'b1);
    chk("os_load_freq", freq_ctrl, 8'd1);
    @(negedge clk_100kHz);
    hold(8'd10);
    hold(8'd15);
    hold(8'd20);
    chk("os_end_busy", busy, 1'b0);
    chk("os_end_done", sweep_done, 1'b1);
    chk("os_end_freq", freq_ctrl, 8'd20);
    @(negedge clk_100kHz);
    chk("os_done_once", sweep_done, 1'b0);
    chk("os_hold_freq", freq_ctrl, 8'd20);

    // Ping-pong 10..20 step 5, then stop
    start_sweep(8'd10, 8'd20, 8'd5, 1'b1);
    @(negedge clk_100kHz);
    hold(8'd10);
    hold(8'd15);
    hold(8'd20);
    hold(8'd15);
    hold(8'd10);
    hold(8'd15);
    chk("pp_next", freq_ctrl, 8'd20);
    @(negedge clk_100kHz);
    stop_pulse = 1'b1;
    @(negedge clk_100kHz);
    stop_pulse = 1'b0;
    chk("pp_stop_busy", busy, 1'b0);
    chk("pp_stop_freq", freq_ctrl, 8'd20);
    chk("pp_stop_done", sweep_done, 1'b0);
    repeat (5) @(negedge clk_100kHz);
    chk("pp_idle_freq", freq_ctrl, 8'd20);
    chk("pp_idle_busy", busy, 1'b0);

    // Rejected configuration
    start_sweep(8'd30, 8'd20, 8'd5, 1'b0);
    chk("cfg_err_pulse", cfg_err, 1'b1);
    chk("cfg_err_busy", busy, 1'b0);
    chk("cfg_err_freq", freq_ctrl, 8'd20);
    @(negedge clk_100kHz);
    chk("cfg_err_once", cfg_err, 1'b0);

    // Clamped bounds and zero step: full 1..128 sweep
    start_sweep(8'd0, 8'd200, 8'd0, 1'b0);
    chk("full_cfg_err", cfg_err, 1'b0);
    @(negedge clk_100kHz);
    for (int v = 1; v <= 128; v++) hold(8'(v));
    chk("full_end_busy", busy, 1'b0);
    chk("full_end_done", sweep_done, 1'b1);
    chk("full_end_freq", freq_ctrl, 8'd128);

    // Start and stop together stays idle
    sweep_lo = 8'd10; sweep_hi = 8'd20; sweep_step = 8'd5; pingpong = 1'b0;
    start_pulse = 1'b1; stop_pulse = 1'b1;
    @(negedge clk_100kHz);
    start_pulse = 1'b0; stop_pulse = 1'b0;
    chk("ss_busy", busy, 1'b0);
    @(negedge clk_100kHz);
    chk("ss_busy2", busy, 1'b0);
    chk("ss_freq", freq_ctrl, 8'd128);

    // inc during DWELL is ignored
    start_sweep(8'd10, 8'd20, 8'd5, 1'b0);
    @(negedge clk_100kHz);
    chk("dw_freq", freq_ctrl, 8'd10);
    inc_pulse = 1'b1;
    @(negedge clk_100kHz);
    inc_pulse = 1'b0;
    chk("dw_inc_ignored", freq_ctrl, 8'd10);
    chk("dw_busy", busy, 1'b1);

    // Asynchronous reset mid-DWELL
    #2 rst_ = 1'b0;
    #1 chk_reset_outputs("async_rst");
    @(negedge clk_100kHz);
    chk_reset_outputs("rst_held");
    rst_ = 1'b1;
    @(negedge clk_100kHz);
    chk("post_rst_busy", busy, 1'b0);
    man_step(0, 8'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
